leb128_fetch: RTL

- Immediate-operand fetch stage between the genrom byte-window port and the core's execute logic.
- On request, reads a WebAssembly LEB128 immediate (i32/i64, signed or unsigned) starting at a byte address.
- Decodes it over one or more ROM window reads and returns the 64-bit value, the byte length consumed and an error code.
- Used by i32.const/i64.const and by branch/local index operands.

---
 rtl/leb128_fetch.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/leb128_fetch.sv
// leb128_fetch: decodes one WebAssembly LEB128 immediate (i32/i64, signed or
// unsigned) from the registered genrom byte window, one chunk per FETCH/DECODE pair.
module leb128_fetch #(
    parameter int MEM_DEPTH  = 4,
    parameter int MEM_EXTRA  = 4,
    parameter int CHUNK_LOG2 = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [MEM_DEPTH:0]           addr_in,
    input  logic                         signed_in,
    input  logic                         wide_in,
    output logic                         busy,
    output logic                         done,
    output logic [63:0]                  value,
    output logic [3:0]                   length,
    output logic [1:0]                   error,
    output logic [MEM_DEPTH:0]           mem_addr,
    output logic [MEM_EXTRA-1:0]         mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0]  mem_data,
    input  logic                         mem_error
);
    localparam int AW   = MEM_DEPTH + 1;
    localparam int CB   = 2 ** CHUNK_LOG2;
    // 10 bytes x 7 bits; the top 6 bits only matter for sign extension.
    localparam int AccW = 70;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StFetch  = 2'd1;
    localparam logic [1:0] StDecode = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic            signed_q, signed_d;
    logic            wide_q, wide_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [63:0]     value_q, value_d;
    logic [3:0]      length_q, length_d;
    logic [1:0]      error_q, error_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;

    logic [3:0]      maxb;
    logic [AccW-1:0] acc_n;
    logic [3:0]      cnt_n;
    logic            found;
    logic            hit_max;
    logic [7:0]      cur_byte;
    logic [7:0]      last_byte;
    logic            final_bad;
    int              shamt;
    logic [AccW-1:0] sext;
    logic [63:0]     result;
    logic            unused_bits;

    assign maxb        = wide_q ? 4'd10 : 4'd5;
    assign unused_bits = ^{sext[AccW-1:64], last_byte[7]};

    // Scan the window in byte order, stopping at a terminator or at MAXB bytes.
    always_comb begin
        acc_n     = acc_q;
        cnt_n     = cnt_q;
        found     = 1'b0;
        hit_max   = 1'b0;
        cur_byte  = 8'h00;
        last_byte = 8'h00;
        for (int i = 0; i < CB; i++) begin
            if (!found && !hit_max) begin
                cur_byte  = mem_data[8*i +: 8];
                acc_n     = acc_n | (AccW'(cur_byte[6:0]) << (7 * int'(cnt_n)));
                cnt_n     = cnt_n + 4'd1;
                last_byte = cur_byte;
                if (!cur_byte[7]) begin
                    found = 1'b1;
                end else if (cnt_n == maxb) begin
                    hit_max = 1'b1;
                end
            end
        end
    end

    // A terminator in the last permitted byte must not carry bits past the operand width.
    always_comb begin
        final_bad = 1'b0;
        if (found && (cnt_n == maxb)) begin
            case ({wide_q, signed_q})
                2'b00:   final_bad = |last_byte[6:4];
                2'b01:   final_bad = last_byte[6:4] != {3{last_byte[3]}};
                2'b10:   final_bad = |last_byte[6:1];
                default: final_bad = (last_byte[6:0] != 7'h00) && (last_byte[6:0] != 7'h7F);
            endcase
        end
    end

    // Sign-extend from bit 7*length-1, then narrow to the operand width.
    always_comb begin
        shamt = AccW - 7 * int'(cnt_n);
        sext  = acc_n;
        if (signed_q && (cnt_n != 4'd0)) begin
            sext = $signed(acc_n << shamt) >>> shamt;
        end
        result = wide_q ? sext[63:0] : {32'h0, sext[31:0]};
    end

    // Next-state and result capture.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        signed_d   = signed_q;
        wide_d     = wide_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        value_d    = value_q;
        length_d   = length_q;
        error_d    = error_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            StIdle: begin
                // done_q blocks a start that coincides with the done pulse.
                if (start && !done_q) begin
                    base_d     = addr_in;
                    signed_d   = signed_in;
                    wide_d     = wide_in;
                    cnt_d      = 4'd0;
                    acc_d      = '0;
                    busy_d     = 1'b1;
                    mem_addr_d = addr_in;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                if (mem_error || found || hit_max) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    value_d = 64'h0;
                    if (mem_error) begin
                        error_d  = 2'd1;
                        length_d = cnt_q;
                    end else if (found && !final_bad) begin
                        error_d  = 2'd0;
                        length_d = cnt_n;
                        value_d  = result;
                    end else begin
                        error_d  = 2'd2;
                        length_d = cnt_n;
                    end
                end else begin
                    cnt_d      = cnt_n;
                    acc_d      = acc_n;
                    mem_addr_d = base_q + AW'(cnt_n);
                    state_d    = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            signed_q   <= 1'b0;
            wide_q     <= 1'b0;
            cnt_q      <= 4'd0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            value_q    <= 64'h0;
            length_q   <= 4'd0;
            error_q    <= 2'd0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            signed_q   <= signed_d;
            wide_q     <= wide_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            value_q    <= value_d;
            length_q   <= length_d;
            error_q    <= error_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign value     = value_q;
    assign length    = length_q;
    assign error     = error_q;
    assign mem_addr  = mem_addr_q;
    assign mem_extra = MEM_EXTRA'(CB - 1);

endmodule
